// File: rtl/phase_bus_cycle.sv
// phase_bus_cycle
//   Four-phase bus cycle engine. Verifies that the phi1..phi4 rotation is
//   clean and locked, then turns core read/write requests into
//   phase-aligned memory strobes, inserts wait states while memory holds
//   ready low, and reports completion with done/err.
//
// Ports
//   clk12, reset            clock and asynchronous active-high reset
//   phi1..phi4              phase inputs, one-hot, one clk12 per phase
//   locked, phase_err       rotation verified / bad-phase pulse while locked
//   req, rw, addr, wdata    core request (held until ack), 1=read
//   ack, done, err, rdata   accept pulse, completion pulse, error qualifier,
//                           read data (held until the next good read)
//   mem_addr, mem_dout      bus address / write data (held after a cycle)
//   mem_din, ready          bus read data / memory ready
//   memen, dbin, we         bus strobes, active-high
//
// Handshake: req/ack is a level/pulse pair. The core holds req (with rw,
// addr and wdata stable) until it sees the one-cycle ack. The cycle ends
// with a one-cycle done; err is only meaningful while done is high.
module phase_bus_cycle #(
    parameter int AW       = 15,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk12,
    input  logic          reset,
    input  logic          phi1,
    input  logic          phi2,
    input  logic          phi3,
    input  logic          phi4,
    output logic          locked,
    output logic          phase_err,
    input  logic          req,
    input  logic          rw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    output logic          memen,
    output logic          dbin,
    output logic          we,
    input  logic          ready
);

    localparam int                WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]    WAIT_LIMIT = WCW'(MAX_WAIT);
    localparam logic [3:0]        LOCK_EDGES = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [3:0]     lock_cnt;
    logic [1:0]     last_idx;
    logic [WCW-1:0] wait_cnt;
    logic           ready_q;
    logic           rw_q;

    logic       onehot;
    logic [1:0] code_idx;
    logic [1:0] exp_idx;
    logic       in_order;
    logic       good, bad, p3, p4;
    logic       accept, to_data, add_wait, fin_ok, fin_err;

    // Phase decode. A run always starts from phi1; after that the expected
    // phase is the successor of the last accepted one.
    always_comb begin
        onehot   = ({phi1, phi2, phi3, phi4} inside {4'b1000, 4'b0100, 4'b0010, 4'b0001});
        code_idx = 2'd0;
        if (phi2) code_idx = 2'd1;
        if (phi3) code_idx = 2'd2;
        if (phi4) code_idx = 2'd3;
        exp_idx  = (lock_cnt == 4'd0) ? 2'd0 : last_idx + 2'd1;
        in_order = onehot && (code_idx == exp_idx);
        good     = locked && in_order;
        bad      = locked && !in_order;
        p3       = good && (code_idx == 2'd2);
        p4       = good && (code_idx == 2'd3);
    end

    // Lock detector: saturating count of consecutive in-order edges.
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            lock_cnt  <= 4'd0;
            last_idx  <= 2'd0;
            locked    <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            phase_err <= locked && !in_order;
            if (in_order) begin
                last_idx <= code_idx;
                if (lock_cnt != LOCK_EDGES) lock_cnt <= lock_cnt + 4'd1;
                locked   <= (lock_cnt >= LOCK_EDGES - 4'd1);
            end else begin
                lock_cnt <= 4'd0;
                locked   <= 1'b0;
            end
        end
    end

    // Bus cycle FSM: state register.
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Bus cycle FSM: next state and per-edge actions. All movement happens
    // on phase edge 4; a bad phase while locked aborts any active cycle.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        to_data  = 1'b0;
        add_wait = 1'b0;
        fin_ok   = 1'b0;
        fin_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (p4 && req) begin
                    state_n = S_ADDR;
                    accept  = 1'b1;
                end
            end
            S_ADDR: begin
                if (bad) begin
                    state_n = S_IDLE;
                    fin_err = 1'b1;
                end else if (p4) begin
                    state_n = S_DATA;
                    to_data = 1'b1;
                end
            end
            S_DATA, S_WAIT: begin
                if (bad) begin
                    state_n = S_IDLE;
                    fin_err = 1'b1;
                end else if (p4) begin
                    if (ready_q) begin
                        state_n = S_IDLE;
                        fin_ok  = 1'b1;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state_n = S_IDLE;
                        fin_err = 1'b1;
                    end else begin
                        state_n  = S_WAIT;
                        add_wait = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            ack      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_dout <= '0;
            memen    <= 1'b0;
            dbin     <= 1'b0;
            we       <= 1'b0;
            rw_q     <= 1'b0;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            ack  <= accept;
            done <= fin_ok || fin_err;
            err  <= fin_err;
            // ready is looked at on phase 3 and acted on at the next phase 4
            if (p3) ready_q <= ready;
            if (accept) begin
                mem_addr <= addr;
                mem_dout <= wdata;
                rw_q     <= rw;
                memen    <= 1'b1;
                dbin     <= rw;
                wait_cnt <= '0;
            end
            if (to_data) we <= !rw_q;
            if (add_wait) wait_cnt <= wait_cnt + 1'b1;
            if (fin_ok || fin_err) begin
                memen <= 1'b0;
                dbin  <= 1'b0;
                we    <= 1'b0;
            end
            if (fin_ok && rw_q) rdata <= mem_din;
        end
    end

endmodule

// File: doc/phase_bus_cycle.md
# phase_bus_cycle

Four-phase bus cycle engine: the consumer of the phi1..phi4 rotation produced by the clock generator. It checks that the phase sequence is clean and locked, then turns core read/write requests into phase-aligned memory strobes (memen, dbin, we). It inserts wait states while the memory holds ready low and returns read data with a done/err completion pulse. It sits between the CPU core and the memory/peripheral bus, all in the clk12 domain.

## Interface

- AW, 15, address width (word address)
- DW, 16, data width
- MAX_WAIT, 15, wait machine-cycles allowed before the cycle is terminated with err

- clk12  in  1  sole clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- phi1, phi2, phi3, phi4  in  1 each  phase inputs; nominally one-hot, one clk12 per phase, order 1→2→3→4→1
- locked  out  1  phase rotation verified
- phase_err  out  1  one-cycle pulse on bad phase while locked
- req  in  1  core request, held until ack
- rw  in  1  1=read, 0=write
- addr  in  AW  request address
- wdata  in  DW  write data
- ack  out  1  one-cycle pulse, request accepted
- done  out  1  one-cycle pulse, cycle complete
- err  out  1  qualifies done: timeout or phase abort
- rdata  out  DW  read data, valid with done&!err, held until next read completes
- mem_addr  out  AW  bus address
- mem_dout  out  DW  bus write data
- mem_din  in  DW  bus read data
- memen, dbin, we  out  1 each  bus strobes, active-high
- ready  in  1  memory ready

## Operation

- "Phase edge N" means the clk12 rising edge at which phiN is sampled high. All outputs are registered and change after that edge.
- Reset: every output is 0. rdata, mem_addr and mem_dout are 0. Lock count is 0 and the FSM is IDLE.
- Lock detector:
  - A valid code is exactly one phi high and equal to the expected next phase. A run must start with phi1.
  - Each valid in-order edge increments a saturating count. locked is set after the 8th consecutive in-order edge (two full rotations).
  - While unlocked, any zero, multi-hot or out-of-order code silently clears the count.
  - While locked, any zero, multi-hot or out-of-order code causes: phase_err=1 for one cycle, locked=0, count cleared, FSM aborted.
- FSM states:
  - IDLE → ADDR: at phase edge 4 with locked&req. Latch addr, wdata and rw into the bus outputs. ack=1 and memen=1; dbin=rw.
  - ADDR → DATA: at the next phase edge 4. For a write, we=1 from here on.
  - DATA/WAIT: ready is sampled at phase edge 3.
    - ready=1: at the following phase edge 4, capture mem_din into rdata (reads only). Assert done=1, err=0, and clear memen, dbin and we. FSM → IDLE.
    - ready=0: at the following phase edge 4, enter or stay in WAIT and increment the wait count.
    - Timeout: if the ready=0 sample occurs when the wait count is already MAX_WAIT, that phase edge 4 instead gives done=1, err=1, strobes cleared, rdata unchanged, FSM → IDLE.
  - Phase abort in ADDR/DATA/WAIT: at the offending edge, done=1, err=1, strobes=0, FSM → IDLE, rdata unchanged. No abort done is issued from IDLE.
- Requests are not accepted while unlocked. req is ignored on non-phase-4 edges.
- mem_addr and mem_dout hold their last values after a cycle ends.

## Timing

- Accept edge = E0 (phase edge 4). ack is high during cycle E0..E1.
- memen and dbin are high from E0 through E8 (8 clk12 cycles) with zero waits. Each wait adds 4 cycles.
- we is high from E4 to completion (writes only).
- ready is sampled at E7, E11, E15, …
- Zero-wait completion: done is high in the cycle after E8. Latency from ack to done is 8 cycles, plus 4·waits.
- Timeout completion: done occurs 8 + 4·MAX_WAIT cycles after ack.
- Back-to-back: if req is held, the next accept is at E12, so ack-to-ack spacing is 12 cycles with zero waits.
- Lock: locked rises after the 8th in-order edge. The first possible accept is at the next phase edge 4.
- Reset mid-cycle: outputs clear immediately (asynchronous). No done is issued.

## Test plan

- Reset, then clean rotation from phi1: all outputs 0 during reset. locked=1 after the 8th edge. No phase_err.
- Read addr=0x1234, mem_din=0xBEEF, ready=1: mem_addr=0x1234; memen and dbin high for 8 cycles; done 8 cycles after ack with rdata=0xBEEF, err=0.
- Write wdata=0xA55A, ready=0 for two phase-3 samples then 1: mem_dout=0xA55A, we high during DATA+WAIT, done 16 cycles after ack, err=0.
- MAX_WAIT=3, ready held 0: done with err=1 exactly 20 cycles after ack; rdata keeps its previous value.
- During DATA of a read, force phi3 low (all-zero code): phase_err pulse, done=1 with err=1 on that edge, memen=0, locked=0. locked returns after 8 good edges.
- req held high over three reads with ready=1: acks 12 cycles apart, three done pulses, no overlap of memen between cycles.
